// File: rtl/serial_link_pkg.sv
// Shared definitions for the MSB-first serial word link.
// Used by both the transmitter and the receiver.
package serial_link_pkg;

  localparam int SERIAL_WORD_W = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_in_shreg.sv
// Serial-in, parallel-out shift register for the word receiver.
// load_first restarts the register with a single (MSB) bit.
module serial_in_shreg #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             load_first,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load_first) begin
      q <= {{(WIDTH-1){1'b0}}, din};
    end else if (shift_en) begin
      q <= {q[WIDTH-2:0], din};
    end
  end

endmodule

// File: rtl/serial_word_receiver.sv
// Receive side of the MSB-first serial word link with a one-word
// holding register, valid/ready output and sticky error flags.
module serial_word_receiver
  import serial_link_pkg::*;
#(
  parameter int WIDTH = SERIAL_WORD_W,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin_valid,
  input  logic             sin,
  input  logic             sof,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             frame_err,
  output logic             overrun,
  input  logic             clr_err
);

  state_t           state, nstate;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] done_word;
  logic [CNT_W-1:0] cnt_nxt;
  logic             shift_en, load_first;
  logic             ld_out, ld_held;
  logic             ferr_set, ovr_set;
  logic             hold_free;

  serial_in_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk        (clk),
    .rst        (rst),
    .shift_en   (shift_en),
    .load_first (load_first),
    .din        (sin),
    .q          (shreg)
  );

  assign done_word = {shreg[WIDTH-2:0], sin};
  assign hold_free = !word_valid || word_ready;
  assign busy      = (state != IDLE);

  always_comb begin
    nstate     = state;
    cnt_nxt    = bit_cnt;
    shift_en   = 1'b0;
    load_first = 1'b0;
    ld_out     = 1'b0;
    ld_held    = 1'b0;
    ferr_set   = 1'b0;
    ovr_set    = 1'b0;
    unique case (state)
      IDLE: begin
        if (sin_valid && sof) begin
          load_first = 1'b1;
          cnt_nxt    = CNT_W'(1);
          nstate     = SHIFT;
        end
      end
      SHIFT: begin
        if (sin_valid && sof) begin
          load_first = 1'b1;
          cnt_nxt    = CNT_W'(1);
          ferr_set   = 1'b1;
        end else if (sin_valid) begin
          shift_en = 1'b1;
          if (bit_cnt == CNT_W'(WIDTH - 1)) begin
            if (hold_free) begin
              ld_out  = 1'b1;
              cnt_nxt = '0;
              nstate  = IDLE;
            end else begin
              cnt_nxt = CNT_W'(WIDTH);
              nstate  = WAIT;
            end
          end else begin
            cnt_nxt = bit_cnt + CNT_W'(1);
          end
        end
      end
      WAIT: begin
        // Bits arriving here are lost, even when the hold frees up.
        ovr_set = sin_valid;
        if (word_ready) begin
          ld_out  = 1'b1;
          ld_held = 1'b1;
          cnt_nxt = '0;
          nstate  = IDLE;
        end
      end
      default: begin
        nstate  = IDLE;
        cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state   <= nstate;
      bit_cnt <= cnt_nxt;
      if (ld_out) begin
        word_out   <= ld_held ? shreg : done_word;
        word_valid <= 1'b1;
      end else if (word_ready) begin
        word_valid <= 1'b0;
      end
      frame_err <= ferr_set | (frame_err & ~clr_err);
      overrun   <= ovr_set | (overrun & ~clr_err);
    end
  end

endmodule

// File: tb/tb_serial_word_receiver.sv
// Bench for serial_word_receiver: table vectors, directed corner
// sequences and random traffic against a frame-level model.
module tb_serial_word_receiver;

  localparam int W  = 10;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sin_valid = 1'b0;
  logic          sin = 1'b0;
  logic          sof = 1'b0;
  logic          word_ready = 1'b0;
  logic          clr_err = 1'b0;
  logic [W-1:0]  word_out;
  logic          word_valid;
  logic          busy;
  logic [CW-1:0] bit_cnt;
  logic          frame_err;
  logic          overrun;

  int nvec = 0;
  int nerr = 0;

  // frame-level reference model
  int           m_n;
  logic [W-1:0] m_acc;
  logic         m_pend;
  logic [W-1:0] m_pword;
  logic [W-1:0] m_out;
  logic         m_valid;
  logic         m_ferr;
  logic         m_ovr;

  serial_word_receiver #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .sin_valid  (sin_valid),
    .sin        (sin),
    .sof        (sof),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .busy       (busy),
    .bit_cnt    (bit_cnt),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .clr_err    (clr_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_n = 0; m_acc = '0; m_pend = 0; m_pword = '0;
    m_out = '0; m_valid = 0; m_ferr = 0; m_ovr = 0;
  endtask

  task automatic model_update();
    logic old_valid;
    logic loaded;
    old_valid = m_valid;
    loaded = 1'b0;
    if (clr_err) begin
      m_ferr = 0;
      m_ovr = 0;
    end
    if (m_pend) begin
      if (sin_valid) m_ovr = 1;
      if (word_ready) begin
        m_out = m_pword; loaded = 1; m_pend = 0; m_n = 0;
      end
    end else if (sin_valid) begin
      if (sof) begin
        if (m_n > 0) m_ferr = 1;
        m_acc = {{(W-1){1'b0}}, sin};
        m_n = 1;
      end else if (m_n > 0) begin
        m_acc = (m_acc << 1) | W'(sin);
        m_n = m_n + 1;
        if (m_n == W) begin
          if (!old_valid || word_ready) begin
            m_out = m_acc; loaded = 1; m_n = 0;
          end else begin
            m_pend = 1; m_pword = m_acc;
          end
        end
      end
    end
    if (loaded) m_valid = 1;
    else if (word_ready) m_valid = 0;
  endtask

  task automatic check_model(input string name);
    logic eb;
    eb = (m_n > 0) || m_pend;
    nvec++;
    if (word_valid !== m_valid || word_out !== m_out || busy !== eb ||
        bit_cnt !== CW'(m_n) || frame_err !== m_ferr || overrun !== m_ovr) begin
      nerr++;
      $display("FAIL %s: got v=%0b w=%h b=%0b c=%0d fe=%0b ov=%0b exp v=%0b w=%h b=%0b c=%0d fe=%0b ov=%0b",
               name, word_valid, word_out, busy, bit_cnt, frame_err, overrun,
               m_valid, m_out, eb, m_n, m_ferr, m_ovr);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got,
                           input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h exp %h", name, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic s, input logic f,
                      input logic r, input logic c, input string name);
    sin_valid = v; sin = s; sof = f; word_ready = r; clr_err = c;
    model_update();
    @(posedge clk);
    #1;
    check_model(name);
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic r,
                           input string name);
    logic [W-1:0] t;
    t = w;
    for (int i = 0; i < W; i++)
      step(1'b1, t[W-1-i], i == 0, r, 1'b0, name);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    check_model("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic          v, s, f, r;
    logic          ev;
    logic [W-1:0]  ew;
    logic          eb;
    logic [CW-1:0] ec;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic [W-1:0] pat;
    logic v, s, f, r, c;
    pat = 10'h2CE;
    for (int i = 0; i < W; i++) begin
      tbl[i].v = 1; tbl[i].s = pat[W-1-i]; tbl[i].f = (i == 0); tbl[i].r = 1;
      tbl[i].ev = (i == W-1);
      tbl[i].ew = (i == W-1) ? 10'h2CE : 10'h000;
      tbl[i].eb = (i != W-1);
      tbl[i].ec = (i == W-1) ? CW'(0) : CW'(i + 1);
    end
    tbl[10] = '{v:0, s:0, f:0, r:1, ev:0, ew:10'h2CE, eb:0, ec:0};

    model_reset();
    #2;
    check_model("reset");
    do_reset();

    // 1: table-driven frame 2CE
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].v, tbl[i].s, tbl[i].f, tbl[i].r, 1'b0, "tbl_model");
      nvec++;
      if (word_valid !== tbl[i].ev || word_out !== tbl[i].ew ||
          busy !== tbl[i].eb || bit_cnt !== tbl[i].ec) begin
        nerr++;
        $display("FAIL tbl[%0d]: got v=%0b w=%h b=%0b c=%0d exp v=%0b w=%h b=%0b c=%0d",
                 i, word_valid, word_out, busy, bit_cnt,
                 tbl[i].ev, tbl[i].ew, tbl[i].eb, tbl[i].ec);
      end
    end

    // 2/3: stall into WAIT, overrun, drain
    send_word(10'h2CE, 1'b0, "s2_w0");
    check_val("s2_first", {22'd0, word_out}, 32'h2CE);
    send_word(10'h155, 1'b0, "s2_w1");
    check_val("s2_busy", {31'd0, busy}, 32'd1);
    check_val("s2_cnt", {28'd0, bit_cnt}, 32'd10);
    check_val("s2_ovr0", {31'd0, overrun}, 32'd0);
    step(1, 1, 0, 0, 0, "s3_drop");
    check_val("s3_ovr", {31'd0, overrun}, 32'd1);
    step(0, 0, 0, 1, 0, "s2_hs1");
    check_val("s2_second", {22'd0, word_out}, 32'h155);
    check_val("s2_valid", {31'd0, word_valid}, 32'd1);
    step(0, 0, 0, 1, 0, "s2_hs2");
    check_val("s2_drained", {31'd0, word_valid}, 32'd0);
    step(0, 0, 0, 0, 1, "s3_clr");
    check_val("s3_ovr_clr", {31'd0, overrun}, 32'd0);

    // bit in the freeing cycle is dropped, clr vs set: set wins
    send_word(10'h0F0, 1'b0, "s3b_w0");
    send_word(10'h30F, 1'b0, "s3b_w1");
    step(1, 1, 1, 1, 1, "s3b_free_drop");
    check_val("s3b_ovr_win", {31'd0, overrun}, 32'd1);
    check_val("s3b_idle", {31'd0, busy}, 32'd0);
    step(0, 0, 0, 1, 1, "s3b_clr");

    // 4: restart mid-frame
    for (int i = 0; i < 4; i++) step(1, 1'(i & 1), i == 0, 1, 0, "s4_part");
    send_word(10'h3FF, 1'b1, "s4_frame");
    check_val("s4_ferr", {31'd0, frame_err}, 32'd1);
    check_val("s4_word", {22'd0, word_out}, 32'h3FF);
    // sof on the final-bit slot restarts
    for (int i = 0; i < W-1; i++) step(1, 1, i == 0, 1, 1, "s4b_part");
    step(1, 0, 1, 1, 0, "s4b_restart");
    check_val("s4b_cnt", {28'd0, bit_cnt}, 32'd1);
    check_val("s4b_ferr", {31'd0, frame_err}, 32'd1);
    for (int i = 0; i < W-1; i++) step(1, 1'(i & 1), 0, 1, 0, "s4b_rest");
    check_val("s4b_word", {22'd0, word_out}, 32'h0AA);

    // 5: async reset mid-frame
    for (int i = 0; i < 6; i++) step(1, 1, i == 0, 1, 0, "s5_part");
    check_val("s5_cnt6", {28'd0, bit_cnt}, 32'd6);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_model("s5_async");
    @(negedge clk);
    rst = 1'b0;
    send_word(10'h001, 1'b1, "s5_frame");
    check_val("s5_word", {22'd0, word_out}, 32'h001);

    // 6: bits without sof while idle
    for (int i = 0; i < 5; i++) step(1, 1, 0, 1, 0, "s6_noise");
    check_val("s6_busy", {31'd0, busy}, 32'd0);
    send_word(10'h2AA, 1'b1, "s6_frame");
    check_val("s6_word", {22'd0, word_out}, 32'h2AA);

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      v = ($urandom_range(0, 9) < 8);
      s = 1'($urandom);
      f = ($urandom_range(0, 29) == 0) || ($urandom_range(0, 9) == 0 && !busy);
      r = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 49) == 0);
      step(v, s, f, r, c, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/serial_word_receiver.md
Name: serial_word_receiver

Overview:
- Receive side of the team's MSB-first serial word link; the shift-left transmitter drives its MSB out each shift cycle.
- Collects WIDTH serial bits, framed by a start-of-frame marker, into a parallel word.
- Presents the word through a valid/ready handshake from a one-word holding register, so reception of the next frame overlaps the consumer's read.
- Flags framing restarts and overruns with sticky error bits.

Parameters:
WIDTH, 10, bits per word; must be >= 2.
CNT_W, $clog2(WIDTH+1), width of the bit counter.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous active-high reset.
sin_valid  input  1  a serial bit is present this cycle.
sin  input  1  serial data bit, MSB of the word first.
sof  input  1  start of frame; qualified by sin_valid; marks the first (MSB) bit.
word_out  output  WIDTH  received word (holding register).
word_valid  output  1  word_out holds an unread word.
word_ready  input  1  consumer accepts word_out when word_valid && word_ready.
busy  output  1  frame in progress or completed frame stalled (state != IDLE).
bit_cnt  output  CNT_W  bits captured in the current frame.
frame_err  output  1  sticky; a sof arrived mid-frame.
overrun  output  1  sticky; a bit arrived while in WAIT.
clr_err  input  1  synchronous clear of frame_err and overrun.

Behaviour:
- Reset, asynchronous: state=IDLE; shift register, word_out and bit_cnt are 0; word_valid, frame_err and overrun are 0.
- Shift rule: every accepted bit does shreg <= {shreg[WIDTH-2:0], sin} and bit_cnt++.
- "Hold free" means !word_valid || word_ready.
- IDLE:
  - sin_valid && sof: shreg <= {0..0, sin}; bit_cnt=1; go to SHIFT.
  - sin_valid && !sof: ignore the bit; no error.
- SHIFT:
  - sin_valid && sof: restart the frame. shreg <= {0..0, sin}; bit_cnt=1; frame_err=1.
  - sin_valid && !sof, bit_cnt < WIDTH-1: shift in.
  - sin_valid && !sof, bit_cnt == WIDTH-1: this is the last bit, and the completed word is {shreg[WIDTH-2:0], sin}.
    - Hold free: word_out <= completed word; word_valid=1; bit_cnt=0; go to IDLE.
    - Hold not free: shreg <= completed word; bit_cnt=WIDTH; go to WAIT.
- WAIT:
  - word_ready (word_valid is necessarily 1): word_out <= shreg; word_valid stays 1; bit_cnt=0; go to IDLE.
  - Any sin_valid in WAIT: the bit is dropped and overrun=1. This applies even in the cycle word_ready frees the hold; that bit is not the start of a new frame.
- Latency: word_valid rises the cycle after the last bit's sin_valid cycle. Back-to-back frames need no idle cycles while the consumer keeps up.
- Handshake:
  - word_out and word_valid are stable while word_valid && !word_ready.
  - A handshake with no new word in the same cycle clears word_valid.
  - A handshake plus a new word in the same cycle keeps word_valid=1 and loads the new data.
- clr_err clears both sticky bits. If clr_err coincides with a new error event, the error wins (bit reads 1).
- Boundary cases:
  - bit_cnt never exceeds WIDTH.
  - sof on the final-bit cycle is treated as a restart, not as completion.
  - Asserting rst mid-frame or in WAIT discards all partial and held data.

Decomposition:
- Package serial_link_pkg:
  - state enum {IDLE, SHIFT, WAIT}.
  - localparam SERIAL_WORD_W = 10, shared with the transmitter.
- One sub-module, serial_in_shreg: a WIDTH-bit serial-in register with shift enable, load-first-bit and parallel-out.
- FSM, counter, holding register and flags stay in the top module.

Test Plan:
1. After reset, sof+sin_valid with bits 1,0,1,1,0,0,1,1,1,0 on consecutive cycles, word_ready=1 -> word_out=10'h2CE and word_valid=1 exactly 1 cycle after the 10th bit, cleared the next cycle; busy=0.
2. word_ready=0; send 10'h2CE, then 10'h155 -> state enters WAIT with busy=1. Raise word_ready -> first the handshake reads 10'h2CE, then word_out=10'h155 with word_valid still 1; overrun=0.
3. While in WAIT from scenario 2, pulse sin_valid=1 with sin=1 -> overrun=1 and the bit is dropped. After clr_err -> overrun=0.
4. Send 4 bits, then sof with a fresh 10-bit frame 10'h3FF -> frame_err=1, word_out=10'h3FF, and the partial bits are discarded.
5. Assert rst asynchronously mid-frame (bit_cnt=6), then release and send 10'h001 -> all outputs 0 during reset; afterwards word_out=10'h001 with no stale bits.
6. sin_valid without sof while IDLE (5 bits) -> no state change, no flags; a following sof frame 10'h2AA is received correctly.
